// File: rtl/datapath.sv
// K&S processor execution half: PC, IR, 4x16 register file, ALU and flags.
// The instruction-type enum lives in k_and_s_pkg so the control unit can share it.
package k_and_s_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNEG   = 4'd10,
        I_BOV    = 4'd11,
        I_BNOV   = 4'd12,
        I_BNNEG  = 4'd13,
        I_BNZERO = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;
endpackage

module datapath
    import k_and_s_pkg::*;
#(
    parameter logic [4:0] PC_RESET = 5'd0,
    parameter int DATA_W = k_and_s_pkg::DATA_W,
    parameter int ADDR_W = k_and_s_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [4];

    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        waddr;
    logic [1:0]        a_idx;
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   wide_res;
    logic              alu_zero;
    logic              alu_neg;
    logic              alu_uov;
    logic              alu_sov;
    logic              unused_ir7;

    assign mem_addr   = ir[ADDR_W-1:0];
    assign unused_ir7 = ir[7];

    // Decode on the opcode byte; unknown opcodes fall back to NOP.
    always_comb begin
        decoded_instruction = I_NOP;
        unique case (ir[15:8])
            8'h00:   decoded_instruction = I_NOP;
            8'h01:   decoded_instruction = I_BRANCH;
            8'h02:   decoded_instruction = I_BZERO;
            8'h03:   decoded_instruction = I_BNEG;
            8'h05:   decoded_instruction = I_BOV;
            8'h06:   decoded_instruction = I_BNOV;
            8'h0A:   decoded_instruction = I_BNNEG;
            8'h0B:   decoded_instruction = I_BNZERO;
            8'h81:   decoded_instruction = I_LOAD;
            8'h82:   decoded_instruction = I_STORE;
            8'h91:   decoded_instruction = I_MOVE;
            8'hA1:   decoded_instruction = I_ADD;
            8'hA2:   decoded_instruction = I_SUB;
            8'hA3:   decoded_instruction = I_AND;
            8'hA4:   decoded_instruction = I_OR;
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    // Register-file port selection depends on the instruction format.
    always_comb begin
        waddr = ir[5:4];
        a_idx = ir[3:2];
        if (decoded_instruction == I_LOAD) begin
            waddr = ir[6:5];
        end else if (decoded_instruction == I_MOVE) begin
            waddr = ir[3:2];
            a_idx = ir[1:0];
        end
    end

    assign a_val    = regs[a_idx];
    assign b_val    = (decoded_instruction == I_MOVE) ? '0 : regs[ir[1:0]];
    assign data_out = regs[ir[6:5]];

    // MOVE passes A through the OR path with B forced to zero.
    always_comb begin
        wide_res = '0;
        alu_uov  = 1'b0;
        alu_sov  = 1'b0;
        unique case (operation)
            2'b00: wide_res = {1'b0, a_val | b_val};
            2'b01: begin
                wide_res = {1'b0, a_val} + {1'b0, b_val};
                alu_uov  = wide_res[DATA_W];
                alu_sov  = (a_val[DATA_W-1] == b_val[DATA_W-1]) &&
                           (wide_res[DATA_W-1] != a_val[DATA_W-1]);
            end
            2'b10: begin
                wide_res = {1'b0, a_val} - {1'b0, b_val};
                alu_uov  = wide_res[DATA_W];
                alu_sov  = (a_val[DATA_W-1] != b_val[DATA_W-1]) &&
                           (wide_res[DATA_W-1] != a_val[DATA_W-1]);
            end
            default: wide_res = {1'b0, a_val & b_val};
        endcase
    end

    assign alu_res  = wide_res[DATA_W-1:0];
    assign alu_zero = (alu_res == '0);
    assign alu_neg  = alu_res[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RESET;
        end else if (pc_enable) begin
            pc <= branch ? mem_addr : pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (ir_enable) begin
            ir <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (write_reg_enable) begin
            regs[waddr] <= c_sel ? alu_res : data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= alu_zero;
            neg_op            <= alu_neg;
            unsigned_overflow <= alu_uov;
            signed_overflow   <= alu_sov;
        end
    end

    assign ram_addr = addr_sel ? mem_addr : pc;

endmodule
